branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Tracks every BEQ from fetch until it resolves in EX/MEM. Holds in-flight predictions from the 2-bit predictor
//  in an in-order queue, compares each against the actual outcome and drives the predictor update inputs.
//  Raises a registered flush plus redirect PC on mispredict. Sits between PREDICTOR and the fetch PC mux.
// PARAMETERS
//  DEPTH    4   in-flight branch entries (power of 2, >=2)
//  AW       32  PC / target width
//  CNT_W    16  width of branch and mispredict counters
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous reset, active low
//  if_beq          in   1      fetch stage holds a BEQ (push request)
//  take_status     in   1      predictor decision for the fetched BEQ
//  if_pc           in   AW     PC of fetched BEQ
//  if_target       in   AW     branch target (pc+imm) of fetched BEQ
//  stall           in   1      pipeline stall; blocks push only
//  resolve_valid   in   1      BEQ present in EX/MEM this cycle (pop request)
//  resolve_taken   in   1      actual outcome (zero flag) of resolving BEQ
//  ex_mem_if_beq   out  1      predictor update strobe
//  taken           out  1      predictor update outcome
//  flush           out  1      squash IF..EX younger instructions, 1-cycle pulse
//  redirect_pc     out  AW     corrected fetch PC, valid while flush=1
//  full            out  1      queue full; fetch must stall on next BEQ
//  underflow_err   out  1      sticky: resolve_valid seen with empty queue
//  branch_cnt      out  CNT_W  resolved branches, saturating
//  mispred_cnt     out  CNT_W  mispredicts, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): queue empty, rd/wr ptrs 0, flush=0, redirect_pc=0, underflow_err=0, counters 0.
//  - Entry = {pred, pc+4, target}; pc+4 computed at push, modulo 2^AW.
//  - push = if_beq & ~stall & ~flush & (~full | pop); push while full without pop is dropped (fetch's error).
//  - pop = resolve_valid & ~empty. Push+pop same cycle: count unchanged, both pointers advance.
//  - Pointers wrap mod DEPTH; extra MSB distinguishes full/empty.
//  - ex_mem_if_beq = pop (combinational); taken = resolve_taken. Predictor updates on the same edge.
//  - mispredict = pop & (head.pred != resolve_taken).
//  - Next edge after mispredict: flush=1 for exactly one cycle; redirect_pc = resolve_taken ? head.target : head.pc+4.
//    Queue is cleared on that same edge (younger entries are wrong-path). Any push that cycle is discarded.
//  - During flush=1 cycle: push blocked; pop also ignored (EX/MEM already squashed).
//  - Correct prediction: no flush, redirect_pc holds its previous value.
//  - resolve_valid & empty: no update strobe, underflow_err set until reset.
//  - branch_cnt +1 per pop; mispred_cnt +1 per mispredict; both stop at all-ones.
//  - stall does not gate pop or flush.
// STRUCTURE
//  - Shared package rv_branch_pkg: typedef branch_entry_t {pred, pc_plus4, target}; localparam PC_INC=4.
//  - One sub-module: branch_queue (DEPTH-entry sync FIFO with push/pop/clear, full/empty). Top holds compare,
//    flush/redirect regs and counters.
// TESTING
//  1 Reset mid-run with 3 entries queued -> empty, full=0, flush=0, counters 0 without any clock edge.
//  2 Push pc=0x100 target=0x140 pred=1, resolve taken=1 -> ex_mem_if_beq=1, taken=1, no flush, branch_cnt=1.
//  3 Push pc=0x200 target=0x180 pred=1, resolve taken=0 -> next cycle flush=1, redirect_pc=0x204, mispred_cnt=1, queue empty.
//  4 Fill 4 entries -> full=1; 5th if_beq with simultaneous pop accepted; without pop dropped, count stays 4.
//  5 Mispredict while if_beq asserted same and next cycle -> both pushes discarded, queue empty after flush.
//  6 resolve_valid on empty queue -> ex_mem_if_beq=0, underflow_err=1 sticky; pc=0xFFFFFFFC pred=0 wraps pc+4=0x0.

Source files
------------

// File: rtl/rv_branch_pkg.sv
// Shared types for the branch resolve unit.
//   branch_entry_t : one in-flight BEQ {prediction, fall-through pc+4, taken target}
//   BR_AW          : PC width carried in a queue entry (the top's AW must not exceed it)
//   PC_INC         : instruction size added to the BEQ pc to form the fall-through pc
package rv_branch_pkg;

    localparam int BR_AW  = 32;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic             pred;
        logic [BR_AW-1:0] pc_plus4;
        logic [BR_AW-1:0] target;
    } branch_entry_t;

    localparam int ENTRY_W = $bits(branch_entry_t);

endpackage

// File: rtl/branch_queue.sv
// In-order synchronous FIFO of in-flight branch entries.
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-low reset
//   clear        drop every entry (takes priority over push/pop)
//   push, wdata  write request and data; ignored while full unless popping
//   pop          read-advance request; ignored while empty
//   rdata        head entry (valid whenever empty=0)
//   full, empty  occupancy flags
// Pointers carry one extra MSB so equal low bits with differing MSBs means full.
module branch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A full queue may accept a push on the same cycle it frees the head slot.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks every fetched BEQ until it resolves in EX/MEM, updates the 2-bit
// predictor and redirects fetch on a mispredict.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   if_beq, take_status, if_pc,      fetch-side push of a BEQ with its prediction,
//   if_target, stall                 pc and target; stall blocks the push only
//   resolve_valid, resolve_taken     EX/MEM-side pop with the actual outcome
//   ex_mem_if_beq, taken             predictor update strobe/outcome (combinational)
//   flush, redirect_pc               registered one-cycle squash and corrected fetch pc
//   full                             queue full; fetch stalls its next BEQ
//   underflow_err                    sticky: resolve seen with nothing in flight
//   branch_cnt, mispred_cnt          saturating event counters
// Handshake: push and pop are fire-and-forget requests with no ready signal.
// Fetch must honour full (a push while full without a pop is dropped), and a
// resolve with an empty queue is not consumed but flagged in underflow_err.
module branch_resolve_unit
    import rv_branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_beq,
    input  logic             take_status,
    input  logic [AW-1:0]    if_pc,
    input  logic [AW-1:0]    if_target,
    input  logic             stall,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             ex_mem_if_beq,
    output logic             taken,
    output logic             flush,
    output logic [AW-1:0]    redirect_pc,
    output logic             full,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    branch_entry_t        push_entry;
    branch_entry_t        head_entry;
    logic [ENTRY_W-1:0]   head_raw;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 mispredict;

    always_comb begin
        push_entry          = '0;
        push_entry.pred     = take_status;
        // Fall-through pc wraps modulo 2^AW.
        push_entry.pc_plus4 = BR_AW'(if_pc + AW'(PC_INC));
        push_entry.target   = BR_AW'(if_target);
    end

    assign head_entry = branch_entry_t'(head_raw);

    // EX/MEM is already squashed during the flush cycle, so its resolve is ignored.
    assign pop        = resolve_valid & ~empty & ~flush;
    assign push       = if_beq & ~stall & ~flush & (~full | pop);
    assign mispredict = pop & (head_entry.pred != resolve_taken);

    assign ex_mem_if_beq = pop;
    assign taken         = resolve_taken;

    // The mispredict clears the queue on the same edge that raises flush; any
    // entry pushed that cycle is wrong-path and goes with it.
    branch_queue #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (mispredict),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_raw),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush         <= 1'b0;
            redirect_pc   <= '0;
            underflow_err <= 1'b0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
        end else begin
            flush <= mispredict;
            // redirect_pc keeps its last value unless a new mispredict occurs.
            if (mispredict) begin
                redirect_pc <= resolve_taken ? AW'(head_entry.target) : AW'(head_entry.pc_plus4);
            end
            if (resolve_valid && empty && !flush) underflow_err <= 1'b1;
            if (pop && (branch_cnt != '1))        branch_cnt  <= branch_cnt + CNT_W'(1);
            if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_beq;
    logic        take_status;
    logic [31:0] if_pc;
    logic [31:0] if_target;
    logic        stall;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        ex_mem_if_beq;
    logic        taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        full;
    logic        underflow_err;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .AW(32), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_beq        (if_beq),
        .take_status   (take_status),
        .if_pc         (if_pc),
        .if_target     (if_target),
        .stall         (stall),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .ex_mem_if_beq (ex_mem_if_beq),
        .taken         (taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .full          (full),
        .underflow_err (underflow_err),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // ---------------- driver tasks (all start and end at posedge+1) ----------------
    task automatic idle_inputs();
        if_beq        = 1'b0;
        take_status   = 1'b0;
        if_pc         = '0;
        if_target     = '0;
        stall         = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic push_beq(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        if_beq      = 1'b1;
        if_pc       = pc;
        if_target   = tgt;
        take_status = pred;
        tick();
        if_beq      = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        push_beq(32'h100, 32'h140, 1'b1);
        push_beq(32'h104, 32'h144, 1'b1);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        push_beq(32'h108, 32'h148, 1'b1);
        push_beq(32'h10C, 32'h14C, 1'b1);
        total_cnt++;
        if (branch_cnt !== 16'd1) $display("FAIL pre_reset_branch_cnt got %0d expected 1", branch_cnt);
        else pass_cnt++;
        // Assert reset between edges and check without any clock edge.
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (full !== 1'b0) $display("FAIL reset_full got %0b expected 0", full); else pass_cnt++;
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL reset_flush got %0b expected 0", flush); else pass_cnt++;
        total_cnt++;
        if (branch_cnt !== 16'd0) $display("FAIL reset_branch_cnt got %0d expected 0", branch_cnt); else pass_cnt++;
        total_cnt++;
        if (mispred_cnt !== 16'd0) $display("FAIL reset_mispred_cnt got %0d expected 0", mispred_cnt); else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got %0h expected 0", redirect_pc); else pass_cnt++;
        total_cnt++;
        if (underflow_err !== 1'b0) $display("FAIL reset_underflow got %0b expected 0", underflow_err); else pass_cnt++;
        resolve_valid = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL reset_queue_empty got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        resolve_valid = 1'b0;
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_predict_taken();
        apply_reset();
        push_beq(32'h100, 32'h140, 1'b1);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b1) $display("FAIL taken_strobe got %0b expected 1", ex_mem_if_beq); else pass_cnt++;
        total_cnt++;
        if (taken !== 1'b1) $display("FAIL taken_outcome got %0b expected 1", taken); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL taken_no_flush got %0b expected 0", flush); else pass_cnt++;
        total_cnt++;
        if (branch_cnt !== 16'd1) $display("FAIL taken_branch_cnt got %0d expected 1", branch_cnt); else pass_cnt++;
        total_cnt++;
        if (mispred_cnt !== 16'd0) $display("FAIL taken_mispred_cnt got %0d expected 0", mispred_cnt); else pass_cnt++;
    endtask

    task automatic test_mispredict();
        push_beq(32'h200, 32'h180, 1'b1);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b1) $display("FAIL mis_strobe got %0b expected 1", ex_mem_if_beq); else pass_cnt++;
        total_cnt++;
        if (taken !== 1'b0) $display("FAIL mis_outcome got %0b expected 0", taken); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL mis_flush got %0b expected 1", flush); else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h204) $display("FAIL mis_redirect got %0h expected 204", redirect_pc); else pass_cnt++;
        total_cnt++;
        if (mispred_cnt !== 16'd1) $display("FAIL mis_mispred_cnt got %0d expected 1", mispred_cnt); else pass_cnt++;
        total_cnt++;
        if (branch_cnt !== 16'd2) $display("FAIL mis_branch_cnt got %0d expected 2", branch_cnt); else pass_cnt++;
        tick();
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL mis_flush_pulse got %0b expected 0", flush); else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h204) $display("FAIL mis_redirect_hold got %0h expected 204", redirect_pc); else pass_cnt++;
        resolve_valid = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL mis_queue_empty got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic test_full();
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            logic p;
            p = (i % 2 == 0) ? 1'b1 : 1'b0;
            exp_q.push_back(p);
            push_beq(32'h400 + 32'(i * 16), 32'h800 + 32'(i * 16), p);
            if (i == 2) begin
                total_cnt++;
                if (full !== 1'b0) $display("FAIL full_at3 got %0b expected 0", full); else pass_cnt++;
            end
        end
        total_cnt++;
        if (full !== 1'b1) $display("FAIL full_at4 got %0b expected 1", full); else pass_cnt++;
        // 5th BEQ with simultaneous pop: accepted.
        if_beq = 1'b1; if_pc = 32'h500; if_target = 32'h900; take_status = 1'b1;
        resolve_valid = 1'b1; resolve_taken = exp_q.pop_front();
        exp_q.push_back(1'b1);
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b1) $display("FAIL full_pushpop_strobe got %0b expected 1", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (full !== 1'b1) $display("FAIL full_after_pushpop got %0b expected 1", full); else pass_cnt++;
        // 6th BEQ without pop: dropped.
        if_pc = 32'h600; if_target = 32'hA00; take_status = 1'b0;
        tick();
        if_beq = 1'b0;
        total_cnt++;
        if (full !== 1'b1) $display("FAIL full_after_drop got %0b expected 1", full); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1'b1; resolve_taken = exp_q.pop_front();
            #1;
            total_cnt++;
            if (ex_mem_if_beq !== 1'b1) $display("FAIL drain_strobe_%0d got %0b expected 1", i, ex_mem_if_beq); else pass_cnt++;
            tick();
            resolve_valid = 1'b0;
            total_cnt++;
            if (flush !== 1'b0) $display("FAIL drain_order_%0d flush got %0b expected 0", i, flush); else pass_cnt++;
        end
        total_cnt++;
        if (full !== 1'b0) $display("FAIL drain_full got %0b expected 0", full); else pass_cnt++;
        total_cnt++;
        if (branch_cnt !== 16'd5) $display("FAIL drain_branch_cnt got %0d expected 5", branch_cnt); else pass_cnt++;
        resolve_valid = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL drain_empty got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic test_flush_discard();
        apply_reset();
        push_beq(32'h300, 32'h380, 1'b0);
        if_beq = 1'b1; if_pc = 32'h400; if_target = 32'h480; take_status = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b1) $display("FAIL fd_strobe got %0b expected 1", ex_mem_if_beq); else pass_cnt++;
        tick();
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL fd_flush got %0b expected 1", flush); else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h380) $display("FAIL fd_redirect got %0h expected 380", redirect_pc); else pass_cnt++;
        if_pc = 32'h500; if_target = 32'h580;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL fd_pop_ignored got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        tick();
        if_beq = 1'b0; resolve_valid = 1'b0;
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL fd_flush_end got %0b expected 0", flush); else pass_cnt++;
        total_cnt++;
        if (branch_cnt !== 16'd1) $display("FAIL fd_branch_cnt got %0d expected 1", branch_cnt); else pass_cnt++;
        resolve_valid = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL fd_queue_empty got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset();
        stall = 1'b1;
        push_beq(32'h600, 32'h640, 1'b1);
        tick();
        total_cnt++;
        if (full !== 1'b0) $display("FAIL stall_full got %0b expected 0", full); else pass_cnt++;
        stall = 1'b0;
        push_beq(32'h700, 32'h740, 1'b1);
        stall = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b1) $display("FAIL stall_pop_allowed got %0b expected 1", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0; stall = 1'b0;
        total_cnt++;
        if (branch_cnt !== 16'd1) $display("FAIL stall_branch_cnt got %0d expected 1", branch_cnt); else pass_cnt++;
        resolve_valid = 1'b1;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL stall_push_blocked got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic test_underflow_wrap();
        apply_reset();
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        #1;
        total_cnt++;
        if (ex_mem_if_beq !== 1'b0) $display("FAIL uf_strobe got %0b expected 0", ex_mem_if_beq); else pass_cnt++;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (underflow_err !== 1'b1) $display("FAIL uf_set got %0b expected 1", underflow_err); else pass_cnt++;
        total_cnt++;
        if (branch_cnt !== 16'd0) $display("FAIL uf_branch_cnt got %0d expected 0", branch_cnt); else pass_cnt++;
        tick();
        total_cnt++;
        if (underflow_err !== 1'b1) $display("FAIL uf_sticky got %0b expected 1", underflow_err); else pass_cnt++;
        // Mispredict to a non-zero target first so the wrap to 0 is observable.
        push_beq(32'h10, 32'h40, 1'b0);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (redirect_pc !== 32'h40) $display("FAIL wrap_pre_redirect got %0h expected 40", redirect_pc); else pass_cnt++;
        tick();
        push_beq(32'hFFFF_FFFC, 32'h20, 1'b0);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL wrap_pred0_flush got %0b expected 0", flush); else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h40) $display("FAIL wrap_pred0_redirect got %0h expected 40", redirect_pc); else pass_cnt++;
        push_beq(32'hFFFF_FFFC, 32'h20, 1'b1);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL wrap_flush got %0b expected 1", flush); else pass_cnt++;
        total_cnt++;
        if (redirect_pc !== 32'h0) $display("FAIL wrap_redirect got %0h expected 0", redirect_pc); else pass_cnt++;
        total_cnt++;
        if (mispred_cnt !== 16'd2) $display("FAIL wrap_mispred_cnt got %0d expected 2", mispred_cnt); else pass_cnt++;
        total_cnt++;
        if (underflow_err !== 1'b1) $display("FAIL wrap_uf_sticky got %0b expected 1", underflow_err); else pass_cnt++;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_predict_taken();
        test_mispredict();
        test_full();
        test_flush_discard();
        test_stall();
        test_underflow_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
